filter_switch_sequencer: RTL

FILTER_SWITCH_SEQUENCER -- requirements
Module: filter_switch_sequencer

---
 rtl/filter_switch_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/filter_switch_sequencer.sv
// Fades gain out/in around filter switches, flushing filter history at zero gain; one-cycle registered response.
// No backpressure: sample_tick paces fades, flush_req is held until flush_ack or FLUSH_TIMEOUT cycles.
module filter_switch_sequencer #(
  parameter int GAIN_W        = 8,
  parameter int STEP          = 32,
  parameter int FLUSH_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              play_en,
  input  logic [2:0]        filter_req,
  input  logic              sample_tick,
  input  logic              flush_ack,
  output logic [2:0]        active_filter,
  output logic [GAIN_W-1:0] gain,
  output logic              flush_req,
  output logic              busy,
  output logic              mute,
  output logic              flush_err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FADE_IN  = 3'd1;
  localparam logic [2:0] S_RUN      = 3'd2;
  localparam logic [2:0] S_FADE_OUT = 3'd3;
  localparam logic [2:0] S_FLUSH    = 3'd4;

  localparam int                CNT_W      = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [GAIN_W:0]   STEP_X     = (GAIN_W + 1)'(STEP);
  localparam logic [GAIN_W:0]   GAIN_MAX_X = {1'b0, {GAIN_W{1'b1}}};
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(FLUSH_TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic [2:0]        filt_q, filt_d;
  logic              flush_req_q, flush_req_d;
  logic              busy_q, busy_d;
  logic              flush_err_q, flush_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [2:0]        san;
  logic              changed;
  logic [GAIN_W:0]   gain_up;
  logic [GAIN_W:0]   gain_dn;
  logic              timeout;
  logic              flush_done;

  always_comb begin
    san        = (filter_req > 3'd5) ? 3'd0 : filter_req;
    changed    = !play_en || (san != filt_q);
    gain_up    = {1'b0, gain_q} + STEP_X;
    if (gain_up > GAIN_MAX_X) begin
      gain_up = GAIN_MAX_X;
    end
    gain_dn    = ({1'b0, gain_q} > STEP_X) ? ({1'b0, gain_q} - STEP_X) : '0;
    timeout    = !flush_ack && (cnt_q == CNT_LAST);
    flush_done = flush_ack || timeout;

    state_d     = state_q;
    gain_d      = gain_q;
    filt_d      = filt_q;
    flush_req_d = flush_req_q;
    flush_err_d = flush_err_q;
    cnt_d       = '0;

    case (state_q)
      S_IDLE: begin
        gain_d = '0;
        if (play_en) begin
          filt_d  = san;
          state_d = S_FADE_IN;
        end
      end
      S_FADE_IN: begin
        // An abort freezes gain for this cycle; the fade-out starts from here.
        if (changed) begin
          state_d = S_FADE_OUT;
        end else if (sample_tick) begin
          gain_d = gain_up[GAIN_W-1:0];
          if (gain_up == GAIN_MAX_X) begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        gain_d = GAIN_MAX_X[GAIN_W-1:0];
        if (changed) begin
          state_d = S_FADE_OUT;
        end
      end
      S_FADE_OUT: begin
        if (gain_q == '0) begin
          if (play_en) begin
            state_d     = S_FLUSH;
            flush_req_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else if (sample_tick) begin
          gain_d = gain_dn[GAIN_W-1:0];
        end
      end
      S_FLUSH: begin
        cnt_d = cnt_q + 1'b1;
        // The filter code is taken at handshake completion so the last request wins.
        if (flush_done) begin
          filt_d      = san;
          flush_req_d = 1'b0;
          cnt_d       = '0;
          if (timeout) begin
            flush_err_d = 1'b1;
          end
          state_d = play_en ? S_FADE_IN : S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        gain_d      = '0;
        flush_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d == S_FADE_IN) || (state_d == S_FADE_OUT) || (state_d == S_FLUSH);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      gain_q      <= '0;
      filt_q      <= 3'd0;
      flush_req_q <= 1'b0;
      busy_q      <= 1'b0;
      flush_err_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gain_q      <= gain_d;
      filt_q      <= filt_d;
      flush_req_q <= flush_req_d;
      busy_q      <= busy_d;
      flush_err_q <= flush_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign active_filter = filt_q;
  assign gain          = gain_q;
  assign flush_req     = flush_req_q;
  assign busy          = busy_q;
  assign flush_err     = flush_err_q;
  assign mute          = (gain_q == '0);

endmodule
